// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MIPS-style multiply/divide unit with HI/LO registers.
// One operand bit is processed per cycle: shift-add multiply on magnitudes,
// restoring divide on magnitudes, with the sign fix-up applied in FINISH.
// Optional feature macro: MDU_DIV_EN. When undefined, the divider is not built
// and DIV/DIVU requests finish immediately with Op_err set and HI/LO untouched.
module mul_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              Start,
  input  logic [1:0]        Op,
  input  logic [DATA_W-1:0] Operand_A,
  input  logic [DATA_W-1:0] Operand_B,
  input  logic              Hi_we,
  input  logic              Lo_we,
  input  logic [DATA_W-1:0] Wr_data,
  input  logic              Cancel,
  output logic              Busy,
  output logic              Done,
  output logic              Div_by_zero,
  output logic              Op_err,
  output logic [DATA_W-1:0] Hi,
  output logic [DATA_W-1:0] Lo
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;     // |B|: multiplicand addend or divisor
  logic [2*DATA_W-1:0] acc_q, acc_d;         // {upper: partial product / remainder, lower: multiplier / quotient}
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                done_q, done_d;
  logic                dbz_q, dbz_d;
  logic                operr_q, operr_d;

  // Magnitudes of the incoming operands (Op[0]=0 selects the signed variants).
  logic                sgn_in;
  logic [DATA_W-1:0]   abs_a, abs_b;
  // Per-step datapath and fix-up terms.
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_next;
  logic [2*DATA_W-1:0] step_next;
  logic                sgn_q, res_neg, rem_neg;
  logic [2*DATA_W-1:0] prod_fix;
`ifdef MDU_DIV_EN
  logic [DATA_W:0]     rem_sh, rem_diff;
  logic [2*DATA_W-1:0] div_next;
`endif

  // Operand magnitudes, one iteration step and the final sign fix-up.
  always_comb begin
    sgn_in   = ~Op[0];
    abs_a    = (sgn_in && Operand_A[DATA_W-1]) ? -Operand_A : Operand_A;
    abs_b    = (sgn_in && Operand_B[DATA_W-1]) ? -Operand_B : Operand_B;
    mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, (acc_q[0] ? mcand_q : {DATA_W{1'b0}})};
    mul_next = {mul_sum, acc_q[DATA_W-1:1]};
`ifdef MDU_DIV_EN
    rem_sh   = acc_q[2*DATA_W-1:DATA_W-1];
    rem_diff = rem_sh - {1'b0, mcand_q};
    div_next = rem_diff[DATA_W] ? {rem_sh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0}
                                : {rem_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
    step_next = op_q[1] ? div_next : mul_next;
`else
    step_next = mul_next;
`endif
    sgn_q    = ~op_q[0];
    res_neg  = sgn_q & (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
    rem_neg  = sgn_q & a_q[DATA_W-1];
    prod_fix = res_neg ? -acc_q : acc_q;
  end

  // Next-state and register-update logic for the IDLE/RUN/FINISH sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    operr_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          // Start wins over a simultaneous direct HI/LO write.
          op_d    = Op;
          a_d     = Operand_A;
          b_d     = Operand_B;
          mcand_d = abs_b;
          acc_d   = {{DATA_W{1'b0}}, abs_a};
          cnt_d   = '0;
`ifdef MDU_DIV_EN
          state_d = RUN;
`else
          state_d = Op[1] ? FINISH : RUN;
`endif
        end else begin
          if (Hi_we) hi_d = Wr_data;
          if (Lo_we) lo_d = Wr_data;
        end
      end
      RUN: begin
        if (Cancel) begin
          state_d = IDLE;
        end else begin
          acc_d = step_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
        if (!Cancel) begin
          done_d = 1'b1;
`ifdef MDU_DIV_EN
          if (op_q[1]) begin
            if (b_q == '0) begin
              lo_d  = '1;
              hi_d  = a_q;
              dbz_d = 1'b1;
            end else begin
              lo_d = res_neg ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
              hi_d = rem_neg ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
            end
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
`else
          if (op_q[1]) begin
            operr_d = 1'b1;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      operr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      operr_q <= operr_d;
    end
  end

  assign Busy        = (state_q != IDLE);
  assign Done        = done_q;
  assign Div_by_zero = dbz_q;
  assign Op_err      = operr_q;
  assign Hi          = hi_q;
  assign Lo          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit (DATA_W=32). Stimulus pushes expected
// results; a negedge monitor pops and compares whenever Done is seen.
module tb_mul_div_unit;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        Start, Hi_we, Lo_we, Cancel;
  logic [1:0]  Op;
  logic [31:0] Operand_A, Operand_B, Wr_data;
  logic        Busy, Done, Div_by_zero, Op_err;
  logic [31:0] Hi, Lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    logic        operr;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mul_div_unit #(.DATA_W(32)) dut (
    .clock(clock), .rst_n(rst_n), .Start(Start), .Op(Op),
    .Operand_A(Operand_A), .Operand_B(Operand_B),
    .Hi_we(Hi_we), .Lo_we(Lo_we), .Wr_data(Wr_data), .Cancel(Cancel),
    .Busy(Busy), .Done(Done), .Div_by_zero(Div_by_zero), .Op_err(Op_err),
    .Hi(Hi), .Lo(Lo)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: on every Done pop the oldest expectation; otherwise flags must be low.
  always @(negedge clock) begin
    if (rst_n) begin
      if (Done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 64'(sbq.size()), 64'd1);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          $display("txn done cyc=%0d hi=%h lo=%h dbz=%b operr=%b", cyc, Hi, Lo, Div_by_zero, Op_err);
          chk("done_cycle", 64'(cyc), 64'(e.due));
          chk("hi", {32'b0, Hi}, {32'b0, e.hi});
          chk("lo", {32'b0, Lo}, {32'b0, e.lo});
          chk("div_by_zero", {63'b0, Div_by_zero}, {63'b0, e.dbz});
          chk("op_err", {63'b0, Op_err}, {63'b0, e.operr});
        end
      end else begin
        chk("flags_idle", {62'b0, Div_by_zero, Op_err}, 64'd0);
      end
    end
  end

  // Issue one operation and push its expected result (lat = edges from Start to Done).
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                       input logic dbz, input logic operr, input int lat);
    exp_t e;
    Start = 1'b1; Op = op; Operand_A = a; Operand_B = b;
    e.hi = exp_hi; e.lo = exp_lo; e.dbz = dbz; e.operr = operr; e.due = cyc + 1 + lat;
    sbq.push_back(e);
    if (!operr) begin
      m_hi = exp_hi;
      m_lo = exp_lo;
    end
    $display("txn issue op=%b a=%h b=%h exp hi=%h lo=%h", op, a, b, exp_hi, exp_lo);
    tick();
    Start = 1'b0;
  endtask

  // Divide ops: real results when the divider is built, otherwise an Op_err pulse.
  task automatic issue_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic dbz);
`ifdef MDU_DIV_EN
    issue(op, a, b, exp_hi, exp_lo, dbz, 1'b0, 33);
`else
    issue(op, a, b, m_hi, m_lo, 1'b0, 1'b1, 1);
`endif
  endtask

  task automatic start_only(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; Op = op; Operand_A = a; Operand_B = b;
    $display("txn start-abort op=%b a=%h b=%h", op, a, b);
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("done_timeout", 64'(sbq.size()), 64'd0);
    sbq.delete();
    tick();
  endtask

  initial begin
    int nbusy;
    rst_n = 1'b0; Start = 1'b0; Op = '0; Operand_A = '0; Operand_B = '0;
    Hi_we = 1'b0; Lo_we = 1'b0; Wr_data = '0; Cancel = 1'b0;
    #1;
    chk("rst_state", {Hi, Lo}, 64'd0);
    chk("rst_flags", {60'b0, Busy, Done, Div_by_zero, Op_err}, 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Multiplies
    issue(MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0, 33);
    wait_done();
    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, 33);
    nbusy = 0;
    for (int k = 0; k < 100; k++) begin
      if (Done) break;
      if (Busy) nbusy++;
      tick();
    end
    chk("busy_cycles", 64'(nbusy), 64'd33);
    wait_done();
    issue(MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, 1'b0, 33);
    wait_done();
    issue(MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0, 1'b0, 33);
    wait_done();
    issue(MULTU, 32'h12345678, 32'h10, 32'h1, 32'h23456780, 1'b0, 1'b0, 33);
    wait_done();
    issue(MULT, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 1'b0, 1'b0, 33);
    wait_done();
    issue(MULTU, 32'h80000000, 32'd2, 32'h1, 32'h0, 1'b0, 1'b0, 33);
    wait_done();

    // Direct HI/LO writes in IDLE
    Hi_we = 1'b1; Wr_data = 32'hA5A5A5A5;
    tick();
    Hi_we = 1'b0; Lo_we = 1'b1; Wr_data = 32'h5A5A5A5A;
    tick();
    Lo_we = 1'b0;
    m_hi = 32'hA5A5A5A5; m_lo = 32'h5A5A5A5A;
    $display("txn direct write hi=%h lo=%h", Hi, Lo);
    chk("direct_write", {Hi, Lo}, {m_hi, m_lo});

    // Divides
    issue_div(DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    wait_done();
    issue_div(DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
    wait_done();
    issue_div(DIVU, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF, 1'b1);
    wait_done();
    issue_div(DIV, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0);
    wait_done();
    issue_div(DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);
    wait_done();
    issue_div(DIVU, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 1'b0);
    wait_done();
    chk("div_hilo", {Hi, Lo}, {m_hi, m_lo});

    // Start and Lo_we while busy are ignored
    issue(MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b0, 33);
    repeat (9) tick();
    Start = 1'b1; Op = MULT; Operand_A = 32'd7; Operand_B = 32'd7;
    Lo_we = 1'b1; Wr_data = 32'hDEAD;
    tick();
    Start = 1'b0; Lo_we = 1'b0;
    wait_done();
    chk("busy_ignore", {Hi, Lo}, 64'd6);

    // Start beats Hi_we in IDLE
    Hi_we = 1'b1; Wr_data = 32'hBEEF;
    issue(MULTU, 32'd4, 32'd5, 32'd0, 32'd20, 1'b0, 1'b0, 33);
    Hi_we = 1'b0;
    wait_done();
    chk("start_wins", {Hi, Lo}, 64'd20);

    // Cancel at cycle 5 of a MULT
    start_only(MULT, 32'd9, 32'd9);
    repeat (4) tick();
    Cancel = 1'b1;
    tick();
    Cancel = 1'b0;
    chk("cancel_busy", {63'b0, Busy}, 64'd0);
    repeat (40) tick();
    chk("cancel_hilo", {Hi, Lo}, {m_hi, m_lo});

    // Reset at cycle 15 of an operation
`ifdef MDU_DIV_EN
    start_only(DIVU, 32'd1000, 32'd7);
`else
    start_only(MULTU, 32'd1000, 32'd7);
`endif
    repeat (14) tick();
    rst_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    chk("reset_hilo", {Hi, Lo}, {m_hi, m_lo});
    chk("reset_busy", {63'b0, Busy}, 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (40) tick();
    chk("post_reset_hilo", {Hi, Lo}, 64'd0);
    issue(MULTU, 32'd3, 32'd3, 32'd0, 32'd9, 1'b0, 1'b0, 33);
    wait_done();
    chk("post_reset_op", {Hi, Lo}, 64'd9);

    repeat (5) tick();
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
